// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions,
// write masks and reset values used by cp0_regfile and cp0_timer.
`timescale 1ns/1ps
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  localparam logic [31:0] STATUS_WR_MASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WR_MASK  = 32'h0000_0300;
  localparam logic [31:0] FULL_WR_MASK   = 32'hFFFF_FFFF;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] PRID_VALUE   = 32'h0001_8003;
  localparam logic [31:0] CONFIG_VALUE = 32'h8000_0080;

  function automatic logic [31:0] merge_write(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
    return (wdata & mask) | (cur & ~mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// Count==Compare match and is cleared by a Compare write.
`timescale 1ns/1ps
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
      ti      <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= wr_data;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end

      // A Compare write acknowledges the timer interrupt and beats a match.
      if (compare_wr) begin
        compare <= wr_data;
        ti      <= 1'b0;
      end else if (count == compare && compare != '0) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception controller. Define CP0_PRID_CONFIG_EN to
// expose the read-only PRId(15) and Config(16) registers.
`timescale 1ns/1ps
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VEC_BEV  = 32'hBFC0_0380,
  parameter logic [31:0] EXC_VEC_NORM = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_mtc0_wr,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_result,
  input  logic        wb_exc_valid,
  input  logic [4:0]  wb_exc_code,
  input  logic        wb_eret,
  input  logic [31:0] wb_pc,
  input  logic        wb_in_delay_slot,
  input  logic [31:0] wb_bad_vaddr,
  input  logic [5:0]  ext_int,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_req,
  output logic [31:0] epc_out
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  sw_ip_q;
  logic [5:0]  hw_ip_q;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] cause_rd;
  logic        mtc0_ok;

  // An exception in WB squashes the MTC0 that raised it.
  assign mtc0_ok = wb_mtc0_wr & ~wb_exc_valid;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_wr   (mtc0_ok && wb_dst == REG_COUNT),
    .compare_wr (mtc0_ok && wb_dst == REG_COMPARE),
    .wr_data    (wb_result),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // IP7 is shared between the timer and the top hardware line.
  assign cause_rd = {bd_q, ti, 14'b0, hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q,
                     1'b0, exc_code_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q       <= STATUS_RESET;
      epc_q          <= '0;
      badvaddr_q     <= '0;
      bd_q           <= 1'b0;
      exc_code_q     <= '0;
      sw_ip_q        <= '0;
      hw_ip_q        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      hw_ip_q        <= ext_int;
      redirect_valid <= wb_exc_valid | wb_eret;

      if (wb_exc_valid) begin
        status_q[STATUS_EXL] <= 1'b1;
        exc_code_q           <= wb_exc_code;
        // Nested exceptions keep the original return point.
        if (!status_q[STATUS_EXL]) begin
          epc_q <= wb_in_delay_slot ? wb_pc - 32'd4 : wb_pc;
          bd_q  <= wb_in_delay_slot;
        end
        if (wb_exc_code == EXC_ADEL || wb_exc_code == EXC_ADES)
          badvaddr_q <= wb_bad_vaddr;
        redirect_pc <= status_q[STATUS_BEV] ? EXC_VEC_BEV : EXC_VEC_NORM;
      end else begin
        if (wb_mtc0_wr) begin
          case (wb_dst)
            REG_STATUS: status_q <= merge_write(status_q, wb_result, STATUS_WR_MASK);
            REG_CAUSE:  sw_ip_q  <= wb_result[9:8];
            REG_EPC:    epc_q    <= wb_result;
            default:    ;
          endcase
        end
        // Placed after the MTC0 write so ERET's EXL clear is the last update.
        if (wb_eret) begin
          status_q[STATUS_EXL] <= 1'b0;
          redirect_pc          <= epc_q;
        end
      end
    end
  end

  logic [31:0] rd_cur;
  logic [31:0] rd_mask;

  // NOTE: both outputs get a default before the case so no latch is inferred
  // for unlisted addresses.
  always_comb begin
    rd_cur  = '0;
    rd_mask = '0;
    case (rd_addr)
      REG_BADVADDR: rd_cur = badvaddr_q;
      REG_COUNT:    begin rd_cur = count;    rd_mask = FULL_WR_MASK;   end
      REG_COMPARE:  begin rd_cur = compare;  rd_mask = FULL_WR_MASK;   end
      REG_STATUS:   begin rd_cur = status_q; rd_mask = STATUS_WR_MASK; end
      REG_CAUSE:    begin rd_cur = cause_rd; rd_mask = CAUSE_WR_MASK;  end
      REG_EPC:      begin rd_cur = epc_q;    rd_mask = FULL_WR_MASK;   end
`ifdef CP0_PRID_CONFIG_EN
      REG_PRID:     rd_cur = PRID_VALUE;
      REG_CONFIG:   rd_cur = CONFIG_VALUE;
`endif
      default:      ;
    endcase
    rd_data = (wb_mtc0_wr && rd_addr == wb_dst) ? merge_write(rd_cur, wb_result, rd_mask)
                                                : rd_cur;
  end

  assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                   (|(cause_rd[15:8] & status_q[15:8]));
  assign epc_out = epc_q;

endmodule
